// File: rtl/demo_bus_pkg.sv
// demo_bus_pkg
// Shared definitions for the demo system bus, used by both the master-side
// demo driver and the slave-side responder.
//   bus_state_t  : responder state encoding (IDLE/WAIT/ACCESS/RESP, 2 bits)
//   RW_READ      : rw_mode value for a read request
//   RW_WRITE     : rw_mode value for a write request
//   index_width  : number of address bits needed to index a memory of a given depth
package demo_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } bus_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // A single-word memory still needs one address bit to keep port widths legal.
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demo_slave_ram.sv
// demo_slave_ram
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, one-cycle read latency,
// write-first (a write returns the new data on q). Written so synthesis maps it
// onto block RAM.
//   clk    : clock
//   we     : write enable
//   addr   : word index
//   wdata  : write data
//   q      : registered read data
module demo_slave_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      q         <= wdata;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/demo_slave_responder.sv
// demo_slave_responder
// Application-side responder for one slave port of the demo system bus.
// Accepts single-beat read/write requests, optionally stalls for WAIT_CYCLES
// cycles to emulate a slow peripheral, services the request from a local
// synchronous RAM and pulses s_done on completion. In-range write data is
// mirrored to the LEDs.
//   clk, rst    : clock, synchronous active-high reset
//   s_valid     : request strobe, only looked at while s_ready is high
//   s_rw_mode   : RW_WRITE / RW_READ
//   s_addr      : word address (full width is range-checked)
//   s_wdata     : write data
//   s_ready     : idle and able to accept a request
//   s_done      : one-cycle completion pulse
//   s_rdata     : read data, valid from s_done, held until the next read completes
//   oor_err     : sticky out-of-range flag
//   led         : last in-range write data
//   wr_count    : in-range writes completed (wraps)
//   rd_count    : reads completed, in or out of range (wraps)
module demo_slave_responder
  import demo_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH           = 8,
  parameter int                    SLAVE_MEM_ADDR_WIDTH = 13,
  parameter int                    MEM_DEPTH            = 32,
  parameter int                    WAIT_CYCLES          = 0,
  parameter logic [DATA_WIDTH-1:0] OOR_RDATA            = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  input  logic                            s_rw_mode,
  input  logic [SLAVE_MEM_ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0]           s_wdata,
  output logic                            s_ready,
  output logic                            s_done,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic                            oor_err,
  output logic [DATA_WIDTH-1:0]           led,
  output logic [7:0]                      wr_count,
  output logic [7:0]                      rd_count
);

  localparam int IDX_W = index_width(MEM_DEPTH);

  // One extra bit so a depth of exactly 2**SLAVE_MEM_ADDR_WIDTH is representable.
  localparam logic [SLAVE_MEM_ADDR_WIDTH:0] DEPTH_LIMIT = MEM_DEPTH[SLAVE_MEM_ADDR_WIDTH:0];

  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

  bus_state_t            state;
  logic [3:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rw_q;
  logic                  in_range_q;

  logic                  in_range_now;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  // The range check looks at every address bit, so aliases above the
  // implemented depth are rejected rather than folded onto low words.
  assign in_range_now = ({1'b0, s_addr} < DEPTH_LIMIT);

  // While idle the RAM is pointed at the incoming address so the read is
  // already under way at the accept edge; afterwards the captured index holds
  // it. Either way q carries the requested word during ACCESS, which lets
  // s_rdata become valid together with s_done.
  assign ram_addr = (state == S_IDLE) ? s_addr[IDX_W-1:0] : idx_q;

  // Gating with rst means a reset landing on the ACCESS edge drops the write.
  assign ram_we = (state == S_ACCESS) && (rw_q == RW_WRITE) && in_range_q && !rst;

  demo_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .q     (ram_q)
  );

  // Request FSM. All visible results (s_done, s_rdata, led, counters, oor_err)
  // are registered on the ACCESS->RESP edge so they appear together in the
  // RESP cycle; s_ready returns on the RESP->IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s_ready    <= 1'b1;
      s_done     <= 1'b0;
      s_rdata    <= '0;
      oor_err    <= 1'b0;
      led        <= '0;
      wr_count   <= '0;
      rd_count   <= '0;
      wait_cnt   <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rw_q       <= RW_READ;
      in_range_q <= 1'b0;
    end else begin
      s_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            idx_q      <= s_addr[IDX_W-1:0];
            wdata_q    <= s_wdata;
            rw_q       <= s_rw_mode;
            in_range_q <= in_range_now;
            s_ready    <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_ACCESS: begin
          state  <= S_RESP;
          s_done <= 1'b1;
          if (rw_q == RW_WRITE) begin
            if (in_range_q) begin
              led      <= wdata_q;
              wr_count <= wr_count + 8'd1;
            end else begin
              oor_err <= 1'b1;
            end
          end else begin
            rd_count <= rd_count + 8'd1;
            if (in_range_q) begin
              s_rdata <= ram_q;
            end else begin
              s_rdata <= OOR_RDATA;
              oor_err <= 1'b1;
            end
          end
        end

        S_RESP: begin
          state   <= S_IDLE;
          s_ready <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
